// File: rtl/qsys_design_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit compressed-trace codes into 30-bit frames (with slot count) and hands
// them downstream over a valid/ready port; also reports end-of-test drain status.
module qsys_design_nios2_qsys_0_oci_dct_packer #(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         code,
  output logic                      code_ready,
  input  logic                      flush,
  input  logic                      test_ending,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [CODE_W*SLOTS-1:0]   frame_buffer,
  output logic [CNT_W-1:0]          frame_count,
  output logic [CODE_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended
);

  localparam int unsigned BUF_W = CODE_W * SLOTS;

  logic             flush_pend;
  logic             ending;

  logic             accept;
  logic             slot_free;
  logic             flush_any;
  logic             full;
  logic             launch;

  logic [BUF_W-1:0] dct_buffer_nxt;
  logic [CNT_W-1:0] dct_count_nxt;
  logic             frame_valid_nxt;
  logic [BUF_W-1:0] frame_buffer_nxt;
  logic [CNT_W-1:0] frame_count_nxt;
  logic             flush_pend_nxt;
  logic             ending_nxt;
  logic             test_has_ended_nxt;

  // Ready depends only on registered state, never on this cycle's inputs.
  assign code_ready = (dct_count < CNT_W'(SLOTS)) && !ending;

  always_comb begin
    dct_buffer_nxt     = dct_buffer;
    dct_count_nxt      = dct_count;
    frame_valid_nxt    = frame_valid;
    frame_buffer_nxt   = frame_buffer;
    frame_count_nxt    = frame_count;
    flush_pend_nxt     = flush_pend;
    ending_nxt         = ending || test_ending;
    test_has_ended_nxt = test_has_ended;

    accept    = code_valid && code_ready;
    slot_free = !frame_valid || frame_ready;
    flush_any = flush || flush_pend || ending;
    full      = (dct_count == CNT_W'(SLOTS));
    launch    = slot_free && (full || (flush_any && (dct_count != '0)));

    if (frame_ready) frame_valid_nxt = 1'b0;

    // A launch empties the packing buffer; a same-cycle code starts the next frame.
    if (launch) begin
      frame_buffer_nxt = dct_buffer;
      frame_count_nxt  = dct_count;
      frame_valid_nxt  = 1'b1;
      flush_pend_nxt   = 1'b0;
      if (accept) begin
        dct_buffer_nxt = BUF_W'(code);
        dct_count_nxt  = CNT_W'(1);
      end else begin
        dct_buffer_nxt = '0;
        dct_count_nxt  = '0;
      end
    end else begin
      if (accept) begin
        dct_buffer_nxt = {dct_buffer[BUF_W-CODE_W-1:0], code};
        dct_count_nxt  = dct_count + CNT_W'(1);
      end
      // Flushing an empty buffer is a no-op so empty frames never go out.
      flush_pend_nxt = (flush || flush_pend) && ((dct_count != '0) || accept);
    end

    if (ending && (dct_count == '0) && !frame_valid) test_has_ended_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dct_buffer     <= '0;
      dct_count      <= '0;
      frame_valid    <= 1'b0;
      frame_buffer   <= '0;
      frame_count    <= '0;
      flush_pend     <= 1'b0;
      ending         <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      dct_buffer     <= dct_buffer_nxt;
      dct_count      <= dct_count_nxt;
      frame_valid    <= frame_valid_nxt;
      frame_buffer   <= frame_buffer_nxt;
      frame_count    <= frame_count_nxt;
      flush_pend     <= flush_pend_nxt;
      ending         <= ending_nxt;
      test_has_ended <= test_has_ended_nxt;
    end
  end

endmodule
